// File: rtl/store_merge_unit.sv
// Read-modify-write store unit: merges a byte/half/word/double store into a memory word.
// Optional macro STORE_MISALIGN_TRAP_EN turns misaligned stores into a one-cycle err pulse.
module store_merge_unit #(
  parameter int unsigned DATA_W  = 64,
  parameter int unsigned ADDR_W  = 64,
  parameter int unsigned MEM_LAT = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_data,
  input  logic [1:0]        req_size,
  output logic              mem_rd_en,
  output logic [ADDR_W-1:0] mem_rd_addr,
  input  logic [DATA_W-1:0] mem_rd_data,
  output logic              mem_wr_en,
  output logic [ADDR_W-1:0] mem_wr_addr,
  output logic [DATA_W-1:0] mem_wr_data,
  output logic              done,
  output logic              err
);

  localparam int unsigned BYTES = DATA_W / 8;
  localparam int unsigned OFF_W = $clog2(BYTES);
  localparam int unsigned CNT_W = 3;
  localparam logic [OFF_W:0] NB_FULL = (OFF_W+1)'(BYTES);

  typedef enum logic [1:0] {IDLE, READ, WAIT, WRITE} state_t;

  state_t            state;
  logic [CNT_W-1:0]  cnt;
  logic [ADDR_W-1:0] word_addr;
  logic [DATA_W-1:0] data_q;
  logic [OFF_W-1:0]  off_q;
  logic [OFF_W:0]    nb_q;

  logic [OFF_W-1:0]  req_off;
  logic [OFF_W:0]    req_nb;
  logic              full_word;
  logic [DATA_W-1:0] merged;
  int unsigned       nb_raw;
  int unsigned       off_i;
  int unsigned       nb_i;

  assign req_ready   = (state == IDLE) && !rst;
  assign mem_rd_addr = word_addr;
  assign mem_wr_addr = word_addr;
  assign req_off     = req_addr[OFF_W-1:0];

  always_comb begin
    nb_raw    = 32'd1 << req_size;
    req_nb    = (OFF_W+1)'((nb_raw > BYTES) ? BYTES : nb_raw);
    full_word = (req_nb == NB_FULL) && (req_off == '0);
  end

`ifdef STORE_MISALIGN_TRAP_EN
  logic err_q;
  logic misaligned;
  // nb is a power of two, so OFF mod NB is just the low bits of OFF
  assign misaligned = (({1'b0, req_off} & (req_nb - 1'b1)) != '0);
  assign err = err_q;
`else
  assign err = 1'b0;
`endif

  // Bytes past the end of the word simply never match the loop range
  always_comb begin
    merged = mem_rd_data;
    off_i  = 32'(off_q);
    nb_i   = 32'(nb_q);
    for (int unsigned i = 0; i < BYTES; i++) begin
      if (i >= off_i && i < off_i + nb_i)
        merged[8*i +: 8] = data_q[8*(i-off_i) +: 8];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      cnt       <= '0;
      mem_rd_en <= 1'b0;
      mem_wr_en <= 1'b0;
      done      <= 1'b0;
`ifdef STORE_MISALIGN_TRAP_EN
      err_q     <= 1'b0;
`endif
    end else begin
      mem_rd_en <= 1'b0;
      mem_wr_en <= 1'b0;
      done      <= 1'b0;
`ifdef STORE_MISALIGN_TRAP_EN
      err_q     <= 1'b0;
`endif
      unique case (state)
        IDLE: begin
          if (req_valid) begin
            word_addr <= {req_addr[ADDR_W-1:OFF_W], {OFF_W{1'b0}}};
            data_q    <= req_data;
            off_q     <= req_off;
            nb_q      <= req_nb;
`ifdef STORE_MISALIGN_TRAP_EN
            if (misaligned) begin
              err_q <= 1'b1;
            end else
`endif
            if (full_word) begin
              mem_wr_data <= req_data;
              mem_wr_en   <= 1'b1;
              done        <= 1'b1;
              state       <= WRITE;
            end else begin
              mem_rd_en <= 1'b1;
              state     <= READ;
            end
          end
        end
        READ: begin
          cnt   <= CNT_W'(MEM_LAT - 1);
          state <= WAIT;
        end
        WAIT: begin
          if (cnt == '0) begin
            mem_wr_data <= merged;
            mem_wr_en   <= 1'b1;
            done        <= 1'b1;
            state       <= WRITE;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        WRITE: state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_store_merge_unit.sv
// Bench for store_merge_unit: directed scenarios plus random stores against a mask-based merge model.
module tb_store_merge_unit;
  localparam int unsigned DATA_W  = 64;
  localparam int unsigned ADDR_W  = 64;
  localparam int unsigned MEM_LAT = 1;

  logic              clk = 1'b0;
  logic              rst;
  logic              req_valid;
  logic              req_ready;
  logic [ADDR_W-1:0] req_addr;
  logic [DATA_W-1:0] req_data;
  logic [1:0]        req_size;
  logic              mem_rd_en;
  logic [ADDR_W-1:0] mem_rd_addr;
  logic [DATA_W-1:0] mem_rd_data;
  logic              mem_wr_en;
  logic [ADDR_W-1:0] mem_wr_addr;
  logic [DATA_W-1:0] mem_wr_data;
  logic              done;
  logic              err;

  int errors = 0;
  int checks = 0;
  logic [63:0] mem [logic [63:0]];

  store_merge_unit #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .MEM_LAT(MEM_LAT)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_addr(req_addr), .req_data(req_data), .req_size(req_size),
    .mem_rd_en(mem_rd_en), .mem_rd_addr(mem_rd_addr), .mem_rd_data(mem_rd_data),
    .mem_wr_en(mem_wr_en), .mem_wr_addr(mem_wr_addr), .mem_wr_data(mem_wr_data),
    .done(done), .err(err)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [63:0] mem_get(input logic [63:0] a);
    return mem.exists(a) ? mem[a] : 64'h0;
  endfunction

  // Reference merge: a byte-lane mask built arithmetically from size and offset
  function automatic logic [63:0] model_merge(input logic [63:0] old, input logic [63:0] data,
                                              input logic [63:0] addr, input logic [1:0] size);
    int unsigned nb, off;
    logic [127:0] mask, ins;
    nb   = 1 << size;
    if (nb > 8) nb = 8;
    off  = int'(addr % 8);
    mask = ((128'd1 << (8*nb)) - 128'd1) << (8*off);
    ins  = {64'd0, data} << (8*off);
    return (old & ~mask[63:0]) | (ins[63:0] & mask[63:0]);
  endfunction

  task automatic do_store(input logic [63:0] addr, input logic [63:0] data, input logic [1:0] size,
                          output logic [63:0] wdata_seen, output bit wrote);
    logic [63:0] waddr, expd, rd_a, wr_a;
    int unsigned nb, off;
    bit full, trap;
    int exp_rd, exp_wr, exp_err;
    int rd_c, wr_c, done_c, err_c, rd_n, wr_n, done_n, err_n, busy_ready;
    waddr = addr & ~64'h7;
    nb    = 1 << size;
    off   = int'(addr % 8);
    full  = (nb == 8) && (off == 0);
`ifdef STORE_MISALIGN_TRAP_EN
    trap  = (off % nb) != 0;
`else
    trap  = 1'b0;
`endif
    expd    = full ? data : model_merge(mem_get(waddr), data, addr, size);
    exp_rd  = (!trap && !full) ? 1 : -1;
    exp_wr  = trap ? -1 : (full ? 1 : 2 + int'(MEM_LAT));
    exp_err = trap ? 1 : -1;
    rd_c = -1; wr_c = -1; done_c = -1; err_c = -1;
    rd_n = 0; wr_n = 0; done_n = 0; err_n = 0; busy_ready = 0;
    rd_a = '0; wr_a = '0; wdata_seen = '0;

    @(negedge clk);
    req_valid = 1'b1; req_addr = addr; req_data = data; req_size = size;
    mem_rd_data = {$urandom, $urandom};
    #1 check("ready_idle", req_ready, 1'b1);
    @(posedge clk);
    #1 req_valid = 1'b0;
    req_addr = {$urandom, $urandom}; req_data = {$urandom, $urandom}; req_size = 2'($urandom);
    for (int c = 1; c <= 5 + int'(MEM_LAT); c++) begin
      @(negedge clk);
      if (mem_rd_en) begin rd_n++; if (rd_c < 0) begin rd_c = c; rd_a = mem_rd_addr; end end
      if (rd_c >= 0 && c == rd_c + int'(MEM_LAT)) mem_rd_data = mem_get(rd_a);
      else mem_rd_data = {$urandom, $urandom};
      if (mem_wr_en) begin
        wr_n++;
        if (wr_c < 0) begin wr_c = c; wr_a = mem_wr_addr; wdata_seen = mem_wr_data; end
      end
      if (done) begin done_n++; if (done_c < 0) done_c = c; end
      if (err) begin err_n++; if (err_c < 0) err_c = c; end
      if (exp_wr > 0 && c <= exp_wr && req_ready) busy_ready++;
    end
    check("rd_cycle", rd_c, exp_rd);
    check("rd_count", rd_n, (exp_rd > 0) ? 1 : 0);
    if (exp_rd > 0) check("rd_addr", rd_a, waddr);
    check("wr_cycle", wr_c, exp_wr);
    check("wr_count", wr_n, (exp_wr > 0) ? 1 : 0);
    check("done_cycle", done_c, exp_wr);
    check("done_count", done_n, (exp_wr > 0) ? 1 : 0);
    check("err_cycle", err_c, exp_err);
    check("ready_busy", busy_ready, 0);
    if (exp_wr > 0) begin
      check("wr_addr", wr_a, waddr);
      check("wr_data", wdata_seen, expd);
      mem[waddr] = expd;
    end
    wrote = (wr_n > 0);
  endtask

  initial begin
    logic [63:0] wd, m0, m1, e1, e2, w1, w2, rd_a;
    bit wr;
    int wr_n, busy, acc2, wr1_c, wr2_c, done_first, rd_pend;

    rst = 1'b1; req_valid = 1'b0; req_addr = '0; req_data = '0; req_size = '0; mem_rd_data = '0;
    repeat (2) @(negedge clk);
    check("rst_ready", req_ready, 1'b0);
    check("rst_rd_en", mem_rd_en, 1'b0);
    check("rst_wr_en", mem_wr_en, 1'b0);
    check("rst_done", done, 1'b0);
    check("rst_err", err, 1'b0);
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    check("post_rst_ready", req_ready, 1'b1);

    mem[64'h1000] = 64'h1122334455667788;
    do_store(64'h1003, 64'hAB, 2'd0, wd, wr);
    check("byte_literal", wd, 64'h11223344AB667788);

    do_store(64'h2004, 64'hDEADBEEF, 2'd2, wd, wr);
    check("word_literal", wd, 64'hDEADBEEF00000000);

    do_store(64'h3000, 64'hCAFEF00D12345678, 2'd3, wd, wr);
    check("double_literal", wd, 64'hCAFEF00D12345678);

    mem[64'h1000] = 64'h1122334455667788;
    do_store(64'h1007, 64'h99EE, 2'd1, wd, wr);
`ifdef STORE_MISALIGN_TRAP_EN
    check("misalign_no_write", wr, 1'b0);
`else
    check("half_trunc_literal", wd, 64'hEE22334455667788);
`endif

    // Reset during WAIT aborts the store
    mem[64'h4000] = 64'h0102030405060708;
    @(negedge clk);
    req_valid = 1'b1; req_addr = 64'h4001; req_data = 64'h77; req_size = 2'd0;
    @(posedge clk); #1 req_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    mem_rd_data = mem[64'h4000];
    rst = 1'b1;
    #1 check("ready_during_rst", req_ready, 1'b0);
    @(posedge clk); #1 rst = 1'b0;
    wr_n = 0;
    @(negedge clk);
    check("ready_after_rst", req_ready, 1'b1);
    for (int c = 0; c < 5; c++) begin
      if (mem_wr_en) wr_n++;
      @(negedge clk);
    end
    check("abort_no_write", wr_n, 0);

    // Held req_valid: second store accepted on the cycle after done
    m0 = 64'hA0A1A2A3A4A5A6A7; m1 = 64'hB0B1B2B3B4B5B6B7;
    mem[64'h5000] = m0; mem[64'h5008] = m1;
    e1 = model_merge(m0, 64'h5A, 64'h5002, 2'd0);
    e2 = model_merge(m1, 64'h1234, 64'h500C, 2'd1);
    busy = 0; acc2 = -1; wr1_c = -1; wr2_c = -1; done_first = -1; rd_pend = -1;
    w1 = '0; w2 = '0; rd_a = '0;
    req_valid = 1'b1; req_addr = 64'h5002; req_data = 64'h5A; req_size = 2'd0;
    @(posedge clk);
    #1 req_addr = 64'h500C; req_data = 64'h1234; req_size = 2'd1;
    for (int c = 1; c <= 12; c++) begin
      @(negedge clk);
      if (mem_rd_en) begin rd_pend = c + int'(MEM_LAT); rd_a = mem_rd_addr; end
      if (c == rd_pend) mem_rd_data = mem_get(rd_a);
      else mem_rd_data = {$urandom, $urandom};
      if (c <= 3 && req_ready) busy++;
      if (done && done_first < 0) done_first = c;
      if (mem_wr_en) begin
        if (wr1_c < 0) begin wr1_c = c; w1 = mem_wr_data; end
        else if (wr2_c < 0) begin wr2_c = c; w2 = mem_wr_data; end
      end
      if (req_valid && req_ready) begin
        acc2 = c;
        @(posedge clk); #1 req_valid = 1'b0;
      end
    end
    check("held_ready_low", busy, 0);
    check("held_done_cycle", done_first, 2 + int'(MEM_LAT));
    check("held_accept2", acc2, 3 + int'(MEM_LAT));
    check("held_wr1_data", w1, e1);
    check("held_wr2_cycle", wr2_c, acc2 + 2 + int'(MEM_LAT));
    check("held_wr2_data", w2, e2);
    mem[64'h5000] = e1; mem[64'h5008] = e2;

    for (int unsigned a = 64'h6000; a < 64'h6020; a += 8) mem[64'(a)] = {$urandom, $urandom};
    for (int n = 0; n < 40; n++) begin
      do_store(64'h6000 + 64'($urandom_range(0, 31)), {$urandom, $urandom}, 2'($urandom), wd, wr);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
